// File: rtl/bus_region_decoder.sv
// Clocked bus-cycle decoder: latches the address on ALE, matches it against programmable
// memory/I/O windows, drives one-hot chip selects and stretches READY by per-region wait states.
module bus_region_decoder #(
    parameter int ADDR_W      = 20,
    parameter int NUM_REGIONS = 4,
    parameter int WAIT_W      = 3,
    localparam int IDX_W      = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   ALE,
    input  logic                   IOM,
    input  logic [ADDR_W-1:0]      A_IN,
    input  logic                   RD_N,
    input  logic                   WR_N,
    input  logic                   CFG_WE,
    input  logic [IDX_W-1:0]       CFG_IDX,
    input  logic                   CFG_EN,
    input  logic                   CFG_IO,
    input  logic [ADDR_W-1:0]      CFG_BASE,
    input  logic [ADDR_W-1:0]      CFG_LIMIT,
    input  logic [WAIT_W-1:0]      CFG_WAIT,
    output logic [ADDR_W-1:0]      Address,
    output logic [NUM_REGIONS-1:0] CS,
    output logic                   READY,
    output logic                   MISS,
    output logic                   BUSY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT,
        S_STROBE
    } state_t;

    state_t                 state_q;
    logic [ADDR_W-1:0]      addr_q;
    logic                   iom_q;
    logic [NUM_REGIONS-1:0] cs_q;
    logic                   miss_q;
    logic [WAIT_W-1:0]      cnt_q;

    logic [NUM_REGIONS-1:0] region_en;
    logic [NUM_REGIONS-1:0] region_io;
    logic [ADDR_W-1:0]      region_base  [NUM_REGIONS];
    logic [ADDR_W-1:0]      region_limit [NUM_REGIONS];
    logic [WAIT_W-1:0]      region_wait  [NUM_REGIONS];

    logic [NUM_REGIONS-1:0] match;
    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic                   strobe;
    logic                   cfg_idx_ok;
    logic                   cnt_nz;

    // I/O windows only see the low 16 address bits; ADDR_W is assumed to be at least 16.
    function automatic logic [ADDR_W-1:0] window_addr(input logic io,
                                                      input logic [ADDR_W-1:0] a);
        return io ? ADDR_W'(a[15:0]) : a;
    endfunction

    function automatic logic in_window(input logic [ADDR_W-1:0] a,
                                       input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W-1:0] limit);
        return (a >= base) && (a <= limit);
    endfunction

    assign strobe     = !RD_N || !WR_N;
    assign cnt_nz     = (cnt_q != '0);
    assign cfg_idx_ok = ({1'b0, CFG_IDX} < (IDX_W + 1)'(NUM_REGIONS));

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            match[i] = region_en[i] && (region_io[i] == iom_q) &&
                       in_window(window_addr(region_io[i], addr_q),
                                 region_base[i], region_limit[i]);
        end
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            iom_q     <= 1'b0;
            cs_q      <= '0;
            miss_q    <= 1'b0;
            cnt_q     <= '0;
            region_en <= '0;
            region_io <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                region_base[i]  <= '0;
                region_limit[i] <= '0;
                region_wait[i]  <= '0;
            end
        end else begin
            if (CFG_WE && cfg_idx_ok) begin
                region_en[CFG_IDX]    <= CFG_EN;
                region_io[CFG_IDX]    <= CFG_IO;
                region_base[CFG_IDX]  <= CFG_BASE;
                region_limit[CFG_IDX] <= CFG_LIMIT;
                region_wait[CFG_IDX]  <= CFG_WAIT;
            end

            // ALE wins in every state: from IDLE it starts a cycle, elsewhere it aborts one.
            if (ALE) begin
                addr_q  <= A_IN;
                iom_q   <= IOM;
                cs_q    <= '0;
                miss_q  <= 1'b0;
                cnt_q   <= '0;
                state_q <= S_DECODE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_IDLE;
                    end
                    S_DECODE: begin
                        if (hit) begin
                            cs_q   <= NUM_REGIONS'(1) << hit_idx;
                            miss_q <= 1'b0;
                            cnt_q  <= region_wait[hit_idx];
                        end else begin
                            cs_q   <= '0;
                            miss_q <= 1'b1;
                            cnt_q  <= '0;
                        end
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (strobe && cnt_nz) begin
                            cnt_q <= cnt_q - WAIT_W'(1);
                        end
                        if (strobe) begin
                            state_q <= S_STROBE;
                        end
                    end
                    S_STROBE: begin
                        if (strobe) begin
                            if (cnt_nz) begin
                                cnt_q <= cnt_q - WAIT_W'(1);
                            end
                        end else begin
                            cs_q    <= '0;
                            miss_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign Address = addr_q;
    assign CS      = cs_q;
    assign MISS    = miss_q;
    assign BUSY    = (state_q != S_IDLE);
    assign READY   = !(((state_q == S_WAIT) || (state_q == S_STROBE)) && strobe && cnt_nz);

endmodule

// File: tb/tb_bus_region_decoder.sv
// Directed bench for bus_region_decoder: scoreboard of expected decode results plus
// READY wait-state counting, abort, reconfiguration and asynchronous reset checks.
module tb_bus_region_decoder;

    logic        CLK;
    logic        RESET_N;
    logic        ALE;
    logic        IOM;
    logic [19:0] A_IN;
    logic        RD_N;
    logic        WR_N;
    logic        CFG_WE;
    logic [1:0]  CFG_IDX;
    logic        CFG_EN;
    logic        CFG_IO;
    logic [19:0] CFG_BASE;
    logic [19:0] CFG_LIMIT;
    logic [2:0]  CFG_WAIT;
    logic [19:0] Address;
    logic [3:0]  CS;
    logic        READY;
    logic        MISS;
    logic        BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [3:0] cs;
        logic       miss;
        int         lows;
    } exp_t;

    exp_t sb[$];

    bus_region_decoder #(
        .ADDR_W(20),
        .NUM_REGIONS(4),
        .WAIT_W(3)
    ) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .ALE(ALE),
        .IOM(IOM),
        .A_IN(A_IN),
        .RD_N(RD_N),
        .WR_N(WR_N),
        .CFG_WE(CFG_WE),
        .CFG_IDX(CFG_IDX),
        .CFG_EN(CFG_EN),
        .CFG_IO(CFG_IO),
        .CFG_BASE(CFG_BASE),
        .CFG_LIMIT(CFG_LIMIT),
        .CFG_WAIT(CFG_WAIT),
        .Address(Address),
        .CS(CS),
        .READY(READY),
        .MISS(MISS),
        .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [3:0] cs, input logic miss,
                            input int lows);
        exp_t e;
        e.tag  = tag;
        e.cs   = cs;
        e.miss = miss;
        e.lows = lows;
        sb.push_back(e);
    endtask

    // Pops the next expectation and compares the decode outputs; returns the expected READY-low count.
    task automatic pop_check(output int lows);
        exp_t e;
        n_checks++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, ".cs"},   32'(CS),   32'(e.cs));
            check({e.tag, ".miss"}, 32'(MISS), 32'(e.miss));
            lows = e.lows;
        end else begin
            lows = 0;
        end
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic en, input logic io,
                             input logic [19:0] base, input logic [19:0] limit,
                             input logic [2:0] wt);
        @(negedge CLK);
        CFG_WE    = 1'b1;
        CFG_IDX   = idx;
        CFG_EN    = en;
        CFG_IO    = io;
        CFG_BASE  = base;
        CFG_LIMIT = limit;
        CFG_WAIT  = wt;
        @(negedge CLK);
        CFG_WE = 1'b0;
    endtask

    task automatic bus_cycle(input string tag, input logic [19:0] addr, input logic iom,
                             input logic wr);
        int lows;
        int exp_lows;
        int guard;
        @(negedge CLK);
        ALE  = 1'b1;
        A_IN = addr;
        IOM  = iom;
        @(negedge CLK);
        ALE  = 1'b0;
        A_IN = 20'h0;
        check({tag, ".addr"}, 32'(Address), 32'(addr));
        check({tag, ".busy"}, 32'(BUSY), 32'd1);
        @(negedge CLK);
        pop_check(exp_lows);
        if (wr) WR_N = 1'b0;
        else    RD_N = 1'b0;
        #1;
        lows  = 0;
        guard = 0;
        while (READY !== 1'b1 && guard < 20) begin
            lows++;
            guard++;
            @(negedge CLK);
            #1;
        end
        check({tag, ".ready_low"}, 32'(lows), 32'(exp_lows));
        @(negedge CLK);
        RD_N = 1'b1;
        WR_N = 1'b1;
        @(negedge CLK);
        check({tag, ".cs_end"},   32'(CS),   32'd0);
        check({tag, ".busy_end"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        int dummy;
        RESET_N   = 1'b0;
        ALE       = 1'b0;
        IOM       = 1'b0;
        A_IN      = 20'h0;
        RD_N      = 1'b1;
        WR_N      = 1'b1;
        CFG_WE    = 1'b0;
        CFG_IDX   = 2'd0;
        CFG_EN    = 1'b0;
        CFG_IO    = 1'b0;
        CFG_BASE  = 20'h0;
        CFG_LIMIT = 20'h0;
        CFG_WAIT  = 3'd0;

        repeat (2) @(negedge CLK);
        check("reset.addr",  32'(Address), 32'd0);
        check("reset.cs",    32'(CS),      32'd0);
        check("reset.ready", 32'(READY),   32'd1);
        check("reset.busy",  32'(BUSY),    32'd0);
        check("reset.miss",  32'(MISS),    32'd0);
        RESET_N = 1'b1;

        push_exp("empty_table", 4'b0000, 1'b1, 0);
        bus_cycle("empty_table", 20'h12345, 1'b0, 1'b0);

        cfg_write(2'd0, 1'b1, 1'b0, 20'h00000, 20'h7FFFF, 3'd0);
        cfg_write(2'd1, 1'b1, 1'b0, 20'h80000, 20'hFFFFF, 3'd2);
        cfg_write(2'd2, 1'b1, 1'b1, 20'h01C00, 20'h01DFF, 3'd1);
        cfg_write(2'd3, 1'b1, 1'b1, 20'h0FF00, 20'h0FF0F, 3'd3);

        push_exp("mem_r0_top", 4'b0001, 1'b0, 0);
        bus_cycle("mem_r0_top", 20'h7FFFE, 1'b0, 1'b0);
        push_exp("mem_r1_base", 4'b0010, 1'b0, 2);
        bus_cycle("mem_r1_base", 20'h80000, 1'b0, 1'b0);
        push_exp("io_r3_limit", 4'b1000, 1'b0, 3);
        bus_cycle("io_r3_limit", 20'hAFF0F, 1'b1, 1'b1);
        push_exp("io_r3_over", 4'b0000, 1'b1, 0);
        bus_cycle("io_r3_over", 20'h0FF10, 1'b1, 1'b1);
        push_exp("io_r2_limit", 4'b0100, 1'b0, 1);
        bus_cycle("io_r2_limit", 20'h01DFF, 1'b1, 1'b0);

        cfg_write(2'd1, 1'b1, 1'b0, 20'h40000, 20'hFFFFF, 3'd2);
        push_exp("overlap_mem", 4'b0001, 1'b0, 0);
        bus_cycle("overlap_mem", 20'h40000, 1'b0, 1'b0);
        push_exp("overlap_io", 4'b0000, 1'b1, 0);
        bus_cycle("overlap_io", 20'h40000, 1'b1, 1'b0);
        cfg_write(2'd1, 1'b1, 1'b0, 20'h80000, 20'hFFFFF, 3'd2);

        cfg_write(2'd3, 1'b1, 1'b1, 20'h0FF0F, 20'h0FF00, 3'd3);
        push_exp("inverted_window", 4'b0000, 1'b1, 0);
        bus_cycle("inverted_window", 20'h0FF08, 1'b1, 1'b0);
        cfg_write(2'd3, 1'b1, 1'b1, 20'h0FF00, 20'h0FF0F, 3'd3);

        // Abort an r1 cycle in WAIT with a fresh ALE.
        push_exp("abort_first", 4'b0010, 1'b0, 2);
        push_exp("abort_second", 4'b0001, 1'b0, 0);
        @(negedge CLK);
        ALE  = 1'b1;
        A_IN = 20'h90000;
        IOM  = 1'b0;
        @(negedge CLK);
        ALE = 1'b0;
        @(negedge CLK);
        pop_check(dummy);
        ALE  = 1'b1;
        A_IN = 20'h00100;
        @(negedge CLK);
        ALE = 1'b0;
        check("abort.cs",   32'(CS),      32'd0);
        check("abort.miss", 32'(MISS),    32'd0);
        check("abort.addr", 32'(Address), 32'h00100);
        check("abort.busy", 32'(BUSY),    32'd1);
        @(negedge CLK);
        pop_check(dummy);
        RD_N = 1'b0;
        #1;
        check("abort.ready", 32'(READY), 32'd1);
        @(negedge CLK);
        RD_N = 1'b1;
        @(negedge CLK);
        check("abort.busy_end", 32'(BUSY), 32'd0);

        // Reprogram r1 to 5 wait states while an r1 cycle is in STROBE.
        push_exp("recfg_cur", 4'b0010, 1'b0, 2);
        @(negedge CLK);
        ALE  = 1'b1;
        A_IN = 20'h80010;
        IOM  = 1'b0;
        @(negedge CLK);
        ALE = 1'b0;
        @(negedge CLK);
        pop_check(dummy);
        RD_N = 1'b0;
        #1;
        check("recfg_cur.ready_a", 32'(READY), 32'd0);
        @(negedge CLK);
        CFG_WE    = 1'b1;
        CFG_IDX   = 2'd1;
        CFG_EN    = 1'b1;
        CFG_IO    = 1'b0;
        CFG_BASE  = 20'h80000;
        CFG_LIMIT = 20'hFFFFF;
        CFG_WAIT  = 3'd5;
        #1;
        check("recfg_cur.ready_b", 32'(READY), 32'd0);
        @(negedge CLK);
        CFG_WE = 1'b0;
        #1;
        check("recfg_cur.ready_c", 32'(READY), 32'd1);
        @(negedge CLK);
        RD_N = 1'b1;
        @(negedge CLK);
        check("recfg_cur.busy_end", 32'(BUSY), 32'd0);
        push_exp("recfg_next", 4'b0010, 1'b0, 5);
        bus_cycle("recfg_next", 20'h80020, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a stretched r1 cycle.
        push_exp("rst_mid", 4'b0010, 1'b0, 5);
        @(negedge CLK);
        ALE  = 1'b1;
        A_IN = 20'h80000;
        IOM  = 1'b0;
        @(negedge CLK);
        ALE = 1'b0;
        @(negedge CLK);
        pop_check(dummy);
        RD_N = 1'b0;
        #1;
        check("rst_mid.ready_before", 32'(READY), 32'd0);
        #1;
        RESET_N = 1'b0;
        #1;
        check("rst_mid.ready", 32'(READY),   32'd1);
        check("rst_mid.cs",    32'(CS),      32'd0);
        check("rst_mid.busy",  32'(BUSY),    32'd0);
        check("rst_mid.addr",  32'(Address), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        RD_N    = 1'b1;
        push_exp("post_reset_r1", 4'b0000, 1'b1, 0);
        bus_cycle("post_reset_r1", 20'h80000, 1'b0, 1'b0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_region_decoder.md
# bus_region_decoder

Parametrised bus-cycle decoder for the Intel8088 bus model. It replaces the fixed address latch and hard-wired chip-select logic with a clocked block that does four things:

- latches the demultiplexed address on ALE;
- matches it against NUM_REGIONS run-time programmable memory or I/O windows;
- drives one-hot chip selects;
- inserts per-region wait states on READY.

It sits between the processor pins interface and the memory/peripheral models.

## Interface

Parameters:
- ADDR_W, 20, latched address width; I/O windows compare bits [15:0] only.
- NUM_REGIONS, 4, number of decode windows and chip selects (1..16).
- WAIT_W, 3, width of the per-region wait-state count.

Ports:
- CLK  input  1  bus clock; all state updates on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- ALE  input  1  address latch enable from processor.
- IOM  input  1  1 = I/O cycle, 0 = memory cycle; sampled with ALE.
- A_IN  input  ADDR_W  multiplexed address ({A, AD}) valid while ALE high.
- RD_N, WR_N  input  1 each  active-low strobes.
- CFG_WE  input  1  region configuration write strobe.
- CFG_IDX  input  $clog2(NUM_REGIONS)  region being written.
- CFG_EN, CFG_IO  input  1 each  region enable; region type (1 = I/O).
- CFG_BASE, CFG_LIMIT  input  ADDR_W each  inclusive window bounds.
- CFG_WAIT  input  WAIT_W  wait states inserted for the region.
- Address  output  ADDR_W  latched address.
- CS  output  NUM_REGIONS  one-hot chip selects, active high.
- READY  output  1  high = transfer may complete.
- MISS  output  1  current cycle matched no region.
- BUSY  output  1  high whenever state != IDLE.

## Operation

- Region table: registers per region (EN, IO, BASE, LIMIT, WAIT).
  - Written on CLK edge when CFG_WE = 1.
  - A write always applies from the next decode; it never alters a cycle already past DECODE.
  - CFG_IDX >= NUM_REGIONS: write ignored.
- Match for region i: EN_i, and IO_i == latched IOM, and BASE_i <= addr <= LIMIT_i.
  - addr = Address[15:0] zero-extended when IO_i = 1; full Address otherwise.
  - Unsigned compare.
  - BASE > LIMIT never matches.
- Several matches: lowest index wins; CS stays strictly one-hot.
- State machine: IDLE -> DECODE -> WAIT -> STROBE -> IDLE.
  - IDLE: edge with ALE = 1 latches A_IN into Address and IOM internally -> DECODE.
  - DECODE, hit: register CS, MISS = 0, load counter = WAIT_i -> WAIT.
  - DECODE, miss: CS = 0, MISS = 1, counter = 0 -> WAIT.
  - WAIT: counter decrements by 1 on each edge where RD_N = 0 or WR_N = 0 and counter != 0.
    - READY = 0 while a strobe is low and counter != 0; READY = 1 otherwise.
    - Strobe seen low -> STROBE.
  - STROBE: counter continues as in WAIT; when RD_N = 1 and WR_N = 1 on an edge -> IDLE, CS cleared, MISS cleared.
- ALE = 1 in any non-IDLE state aborts the current cycle:
  - Address is relatched, CS = 0 and MISS = 0 on that edge;
  - state -> DECODE.
- Address holds its value outside ALE edges; it is not cleared on IDLE.
- RD_N and WR_N both low: treated as one strobe; no error flag.

## Timing

- Reset values:
  - Address = 0, CS = 0, READY = 1, MISS = 0, BUSY = 0, state = IDLE;
  - all regions EN = 0, BASE = 0, LIMIT = 0, WAIT = 0, IO = 0.
- RESET_N low mid-cycle forces all reset values asynchronously, including the region table. The cycle in flight is dropped.
- Edge e with ALE = 1: Address is valid after e.
- CS/MISS valid after edge e+1.
- READY combinational from state, counter and strobes; no extra register stage.
- Strobe first low before edge s, region WAIT = n (n > 0):
  - READY low from the strobe falling until after edge s+n-1;
  - READY high after edge s+n-1, i.e. n low clocks.
- WAIT = 0 or miss: READY never deasserts.
- CS deasserts after the first edge with both strobes high in STROBE.
- Counter saturates at 0; never wraps.

## Test plan

- Reset then idle: RESET_N low 2 clocks -> Address = 0, CS = 0, READY = 1, BUSY = 0; ALE pulse at 0x12345 with no regions enabled -> MISS = 1 after DECODE, READY stays 1.
- Program regions:
  - r0 mem 0x00000–0x7FFFF, wait 0;
  - r1 mem 0x80000–0xFFFFF, wait 2;
  - r2 I/O 0x1C00–0x1DFF, wait 1;
  - r3 I/O 0xFF00–0xFF0F, wait 3.

  Memory read at 0x7FFFE -> CS = 4'b0001, READY never low; memory read at 0x80000 -> CS = 4'b0010, READY low exactly 2 clocks.
- I/O write 0xFF0F with A_IN = 0xAFF0F, IOM = 1 -> CS = 4'b1000, READY low 3 clocks. I/O write 0xFF10 -> MISS = 1, CS = 0.
- Overlap: r0 and r1 both cover 0x40000 -> CS = 4'b0001 only. Same address with IOM = 1 matches no memory region -> MISS.
- Abort and reconfig:
  - ALE reasserted during WAIT of an r1 cycle -> CS drops, new address decoded next edge;
  - CFG write to r1 wait = 5 during STROBE -> current cycle keeps 2, next r1 cycle inserts 5.
- Reset mid-WAIT with READY = 0 -> READY = 1, CS = 0 immediately without CLK; following r1 access -> MISS (table cleared).
